// File: rtl/buf_fifo_pkg.sv
// Shared constants and types for the show-ahead FIFO sequencer that
// drives the 8-entry x 64-bit two-port buffer.
package buf_fifo_pkg;
    localparam int FIFO_DW        = 64;
    localparam int FIFO_AW        = 3;
    localparam int FIFO_DEPTH     = 2 ** FIFO_AW;
    localparam int FIFO_AFULL_THR = 6;

    typedef logic [FIFO_AW:0] level_t;
endpackage

// File: rtl/buf_fifo_ptr.sv
// Wrapping buffer pointer: AW address bits plus a wrap bit, with increment
// enable and synchronous clear.
module buf_fifo_ptr
    import buf_fifo_pkg::*;
#(
    parameter int AW = FIFO_AW
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        inc,
    output logic [AW:0] ptr
);

    logic [AW:0] ptr_r;

    // Pointer register; the wrap bit toggles naturally as the binary count rolls over
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= {(AW + 1){1'b0}};
        end else if (clr) begin
            ptr_r <= {(AW + 1){1'b0}};
        end else if (inc) begin
            ptr_r <= ptr_r + {{AW{1'b0}}, 1'b1};
        end
    end

    assign ptr = ptr_r;

endmodule

// File: rtl/buf_fifo_ctrl.sv
// Show-ahead FIFO sequencer: drives a registered-read two-port buffer and
// prefetches the head entry into its output register to hide read latency.
module buf_fifo_ctrl
    import buf_fifo_pkg::*;
#(
    parameter int DW        = FIFO_DW,
    parameter int AW        = FIFO_AW,
    parameter int AFULL_THR = FIFO_AFULL_THR
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          buf_wr_en,
    output logic [AW-1:0] buf_addr_wr,
    output logic [DW-1:0] buf_wr_data,
    output logic          buf_rd_en,
    output logic [AW-1:0] buf_addr_rd,
    input  logic [DW-1:0] buf_rd_data,
    output logic [AW:0]   level,
    output logic          afull,
    output logic          ovf_err,
    output logic          unf_err
);

    localparam logic [AW:0] DEPTH_C    = (AW + 1)'(2 ** AW);
    localparam logic [AW:0] FULL_LVL_C = (AW + 1)'(2 ** AW + 1);
    localparam logic [AW:0] AFULL_C    = (AW + 1)'(AFULL_THR);

    logic [AW:0] wptr_s;
    logic [AW:0] rptr_s;
    logic [AW:0] mem_cnt_r;
    logic [AW:0] mem_cnt_nxt_s;
    logic [AW:0] level_s;
    logic        m_valid_r;
    logic        ovf_err_r;
    logic        unf_err_r;
    logic        s_ready_s;
    logic        push_s;
    logic        fetch_s;

    buf_fifo_ptr #(.AW(AW)) u_wptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (push_s),
        .ptr (wptr_s)
    );

    buf_fifo_ptr #(.AW(AW)) u_rptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (fetch_s),
        .ptr (rptr_s)
    );

    // Handshake decode; everything is forced low while reset is held
    always_comb begin
        s_ready_s = 1'b0;
        push_s    = 1'b0;
        fetch_s   = 1'b0;
        if (rst) begin
            s_ready_s = 1'b0;
        end else begin
            s_ready_s = (mem_cnt_r != DEPTH_C) && !flush;
            push_s    = s_valid && s_ready_s;
            fetch_s   = (mem_cnt_r != {(AW + 1){1'b0}}) && (!m_valid_r || m_ready) && !flush;
        end
    end

    // Occupancy of the buffer proper; the prefetched head is tracked by m_valid
    always_comb begin
        mem_cnt_nxt_s = mem_cnt_r;
        if (flush) begin
            mem_cnt_nxt_s = {(AW + 1){1'b0}};
        end else begin
            case ({push_s, fetch_s})
                2'b10:   mem_cnt_nxt_s = mem_cnt_r + {{AW{1'b0}}, 1'b1};
                2'b01:   mem_cnt_nxt_s = mem_cnt_r - {{AW{1'b0}}, 1'b1};
                default: mem_cnt_nxt_s = mem_cnt_r;
            endcase
        end
    end

    // Occupancy and head-valid state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_cnt_r <= {(AW + 1){1'b0}};
            m_valid_r <= 1'b0;
        end else begin
            mem_cnt_r <= mem_cnt_nxt_s;
            if (flush) begin
                m_valid_r <= 1'b0;
            end else if (fetch_s) begin
                m_valid_r <= 1'b1;
            end else if (m_ready) begin
                m_valid_r <= 1'b0;
            end
        end
    end

    assign level_s = mem_cnt_r + {{AW{1'b0}}, m_valid_r};

    // Sticky protocol errors survive flush; only reset clears them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_err_r <= 1'b0;
            unf_err_r <= 1'b0;
        end else begin
            if (s_valid && !s_ready_s && (level_s == FULL_LVL_C)) begin
                ovf_err_r <= 1'b1;
            end
            if (m_ready && !m_valid_r) begin
                unf_err_r <= 1'b1;
            end
        end
    end

    assign s_ready     = s_ready_s;
    assign buf_wr_en   = push_s;
    assign buf_addr_wr = wptr_s[AW-1:0];
    assign buf_wr_data = s_data;
    assign buf_rd_en   = fetch_s;
    assign buf_addr_rd = rptr_s[AW-1:0];
    assign m_valid     = m_valid_r;
    assign m_data      = buf_rd_data;
    assign level       = level_s;
    assign afull       = (level_s >= AFULL_C);
    assign ovf_err     = ovf_err_r;
    assign unf_err     = unf_err_r;

endmodule

// File: tb/tb_buf_fifo_ctrl.sv
// Self-checking bench for buf_fifo_ctrl: a behavioural buffer model plus a
// queue-based reference of the show-ahead FIFO.
module tb_buf_fifo_ctrl;
    import buf_fifo_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, s_valid, s_ready, m_valid, m_ready;
    logic        buf_wr_en, buf_rd_en, afull, ovf_err, unf_err;
    logic [63:0] s_data, m_data, buf_wr_data, buf_rd_data;
    logic [2:0]  buf_addr_wr, buf_addr_rd;
    logic [3:0]  level;
    logic [63:0] bmem [8];

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [63:0] mq [$];
    bit          hv;
    logic [63:0] hd;
    int          wcnt, rcnt;
    bit          m_ovf, m_unf;
    bit          e_sready, e_push, e_fetch, e_afull;
    level_t      e_level;

    buf_fifo_ctrl dut (
        .clk(clk), .rst(rst), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .buf_wr_en(buf_wr_en), .buf_addr_wr(buf_addr_wr), .buf_wr_data(buf_wr_data),
        .buf_rd_en(buf_rd_en), .buf_addr_rd(buf_addr_rd), .buf_rd_data(buf_rd_data),
        .level(level), .afull(afull), .ovf_err(ovf_err), .unf_err(unf_err)
    );

    always #5 clk = ~clk;

    // two-port buffer with registered read that holds while rd_en is low
    always @(posedge clk) begin
        if (buf_wr_en) bmem[buf_addr_wr] <= buf_wr_data;
        if (buf_rd_en) buf_rd_data <= bmem[buf_addr_rd];
    end

    task automatic model_clear();
        mq.delete();
        hv = 1'b0; wcnt = 0; rcnt = 0; m_ovf = 1'b0; m_unf = 1'b0;
    endtask

    // apply inputs just after a falling edge and derive this cycle's expectations
    task automatic drive(input bit sv, input logic [63:0] sd, input bit mr, input bit fl);
        s_valid = sv; s_data = sd; m_ready = mr; flush = fl;
        e_level  = level_t'(mq.size() + int'(hv));
        e_afull  = (e_level >= 4'd6);
        e_sready = !rst && (mq.size() != 8) && !fl;
        e_push   = sv && e_sready;
        e_fetch  = !rst && (mq.size() != 0) && (!hv || mr) && !fl;
        #2;
    endtask

    // advance one clock and update the reference
    task automatic tick();
        @(posedge clk);
        if (s_valid && !e_sready && (e_level == 4'd9)) m_ovf = 1'b1;
        if (m_ready && !hv) m_unf = 1'b1;
        if (flush) begin
            mq.delete(); hv = 1'b0; wcnt = 0; rcnt = 0;
        end else begin
            if (e_fetch) begin
                hd = mq.pop_front(); hv = 1'b1; rcnt++;
            end else if (m_ready) begin
                hv = 1'b0;
            end
            if (e_push) begin
                mq.push_back(s_data); wcnt++;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; flush = 1'b0; s_data = 64'd0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b1; m_ready = 1'b1; flush = 1'b0; s_data = 64'd1;
        @(negedge clk);
        #2;
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL rst_s_ready got=%b exp=0", s_ready); end
        total++; if (buf_wr_en !== 1'b0 || buf_rd_en !== 1'b0) begin bad++; $display("FAIL rst_en got=%b%b exp=00", buf_wr_en, buf_rd_en); end
        total++; if (m_valid !== 1'b0 || level !== 4'd0 || afull !== 1'b0) begin bad++; $display("FAIL rst_state got=%b/%0d/%b exp=0/0/0", m_valid, level, afull); end
        total++; if (ovf_err !== 1'b0 || unf_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b%b exp=00", ovf_err, unf_err); end
        do_reset();
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        total++; if (s_ready !== 1'b1 || level !== 4'd0) begin bad++; $display("FAIL post_rst got=%b/%0d exp=1/0", s_ready, level); end
    endtask

    task automatic test_first_push();
        do_reset();
        drive(1'b1, 64'hA5A5_0000_0000_0001, 1'b0, 1'b0);
        total++; if (buf_wr_en !== 1'b1 || buf_addr_wr !== 3'd0) begin bad++; $display("FAIL fp_wr got=%b@%0d exp=1@0", buf_wr_en, buf_addr_wr); end
        total++; if (buf_wr_data !== 64'hA5A5_0000_0000_0001) begin bad++; $display("FAIL fp_wdata got=%h", buf_wr_data); end
        tick();
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        total++; if (buf_rd_en !== 1'b1 || buf_addr_rd !== 3'd0 || m_valid !== 1'b0) begin bad++; $display("FAIL fp_rd got=%b@%0d v=%b exp=1@0 v=0", buf_rd_en, buf_addr_rd, m_valid); end
        tick();
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        total++; if (m_valid !== 1'b1 || m_data !== 64'hA5A5_0000_0000_0001 || level !== 4'd1) begin bad++; $display("FAIL fp_head got=%b %h lvl=%0d", m_valid, m_data, level); end
        tick();
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        total++; if (m_data !== 64'hA5A5_0000_0000_0001 || buf_rd_en !== 1'b0) begin bad++; $display("FAIL fp_hold got=%h rd=%b", m_data, buf_rd_en); end
        tick();
    endtask

    task automatic test_fill_ovf_drain();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 64'(i), 1'b0, 1'b0);
            total++; if (s_ready !== 1'b1 || buf_wr_en !== 1'b1) begin bad++; $display("FAIL fill_rdy i=%0d got=%b%b exp=11", i, s_ready, buf_wr_en); end
            total++; if (afull !== e_afull || level !== e_level) begin bad++; $display("FAIL fill_lvl i=%0d got=%0d/%b exp=%0d/%b", i, level, afull, e_level, e_afull); end
            tick();
        end
        drive(1'b1, 64'hDEAD, 1'b0, 1'b0);
        total++; if (s_ready !== 1'b0 || buf_wr_en !== 1'b0 || level !== 4'd9 || afull !== 1'b1) begin bad++; $display("FAIL full got=%b%b lvl=%0d af=%b exp=00 9 1", s_ready, buf_wr_en, level, afull); end
        tick();
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        total++; if (ovf_err !== 1'b1 || unf_err !== 1'b0) begin bad++; $display("FAIL ovf got=%b%b exp=10", ovf_err, unf_err); end
        tick();
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 64'd0, 1'b1, 1'b0);
            total++; if (m_valid !== 1'b1 || m_data !== 64'(i)) begin bad++; $display("FAIL drain i=%0d got=%b %h exp=1 %h", i, m_valid, m_data, 64'(i)); end
            tick();
        end
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        total++; if (m_valid !== 1'b0 || level !== 4'd0 || s_ready !== 1'b1) begin bad++; $display("FAIL drained got=%b lvl=%0d rdy=%b", m_valid, level, s_ready); end
        tick();
    endtask

    task automatic test_stream();
        logic [63:0] sent [$];
        logic [63:0] d;
        int pops = 0;
        do_reset();
        for (int c = 0; c < 23; c++) begin
            d = {$urandom, $urandom};
            drive(c < 20, d, 1'b1, 1'b0);
            if (c < 20) begin
                sent.push_back(d);
                total++; if (buf_wr_en !== 1'b1 || buf_addr_wr !== 3'(c % 8)) begin bad++; $display("FAIL st_wr c=%0d got=%b@%0d exp=1@%0d", c, buf_wr_en, buf_addr_wr, c % 8); end
            end
            if (c >= 2 && c <= 21) begin
                total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL st_stall c=%0d got=%b exp=1", c, m_valid); end
            end
            if (m_valid === 1'b1) begin
                total++; if (pops >= sent.size() || m_data !== sent[pops]) begin bad++; $display("FAIL st_order pop=%0d got=%h", pops, m_data); end
                pops++;
            end
            tick();
        end
        total++; if (pops != 20) begin bad++; $display("FAIL st_count got=%0d exp=20", pops); end
    endtask

    task automatic test_flush();
        bit found = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 64'(100 + i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 64'h55, 1'b0, 1'b1);
        total++; if (buf_wr_en !== 1'b0 || buf_rd_en !== 1'b0 || s_ready !== 1'b0 || level !== 4'd5) begin bad++; $display("FAIL fl_cyc got=%b%b%b lvl=%0d exp=000 5", buf_wr_en, buf_rd_en, s_ready, level); end
        tick();
        drive(1'b1, 64'h77, 1'b1, 1'b0);
        total++; if (level !== 4'd0 || m_valid !== 1'b0 || s_ready !== 1'b1 || buf_addr_wr !== 3'd0) begin bad++; $display("FAIL fl_after got=%0d %b %b @%0d", level, m_valid, s_ready, buf_addr_wr); end
        tick();
        for (int i = 0; i < 8 && !found; i++) begin
            drive(1'b0, 64'd0, 1'b1, 1'b0);
            if (m_valid === 1'b1) begin
                found = 1'b1;
                total++; if (m_data !== 64'h77) begin bad++; $display("FAIL fl_word got=%h exp=77", m_data); end
            end
            tick();
        end
        if (!found) begin total++; bad++; $display("FAIL fl_timeout got=no_valid exp=valid"); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 64'(200 + i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 64'h99, 1'b1, 1'b0);
        total++; if (buf_rd_en !== 1'b1 || level !== 4'd4) begin bad++; $display("FAIL rm_pre got=%b lvl=%0d exp=1 4", buf_rd_en, level); end
        rst = 1'b1;
        #1;
        total++; if (s_ready !== 1'b0 || buf_wr_en !== 1'b0 || buf_rd_en !== 1'b0) begin bad++; $display("FAIL rm_en got=%b%b%b exp=000", s_ready, buf_wr_en, buf_rd_en); end
        total++; if (m_valid !== 1'b0 || level !== 4'd0 || afull !== 1'b0 || unf_err !== 1'b0) begin bad++; $display("FAIL rm_state got=%b %0d %b %b", m_valid, level, afull, unf_err); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        drive(1'b1, 64'hBEEF, 1'b0, 1'b0);
        total++; if (buf_wr_en !== 1'b1 || buf_addr_wr !== 3'd0 || level !== 4'd0) begin bad++; $display("FAIL rm_push got=%b@%0d lvl=%0d", buf_wr_en, buf_addr_wr, level); end
        tick();
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        total++; if (buf_rd_en !== 1'b1 || buf_addr_rd !== 3'd0) begin bad++; $display("FAIL rm_fetch got=%b@%0d exp=1@0", buf_rd_en, buf_addr_rd); end
        tick();
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        total++; if (m_valid !== 1'b1 || m_data !== 64'hBEEF) begin bad++; $display("FAIL rm_data got=%b %h exp=1 beef", m_valid, m_data); end
        tick();
    endtask

    task automatic test_random();
        bit sv, mr, fl;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            sv = ($urandom % 4) != 0;
            mr = ((c / 60) % 2 == 0) ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
            fl = ($urandom % 50) == 0;
            drive(sv, {$urandom, $urandom}, mr, fl);
            total++; if (s_ready !== e_sready || buf_wr_en !== e_push || buf_rd_en !== e_fetch) begin bad++; $display("FAIL rnd_hs c=%0d got=%b%b%b exp=%b%b%b", c, s_ready, buf_wr_en, buf_rd_en, e_sready, e_push, e_fetch); end
            total++; if ((e_push && buf_addr_wr !== 3'(wcnt % 8)) || (e_fetch && buf_addr_rd !== 3'(rcnt % 8))) begin bad++; $display("FAIL rnd_addr c=%0d got=%0d/%0d exp=%0d/%0d", c, buf_addr_wr, buf_addr_rd, wcnt % 8, rcnt % 8); end
            total++; if (m_valid !== hv || (hv && m_data !== hd)) begin bad++; $display("FAIL rnd_head c=%0d got=%b %h exp=%b %h", c, m_valid, m_data, hv, hd); end
            total++; if (level !== e_level || afull !== e_afull) begin bad++; $display("FAIL rnd_lvl c=%0d got=%0d/%b exp=%0d/%b", c, level, afull, e_level, e_afull); end
            total++; if (ovf_err !== m_ovf || unf_err !== m_unf) begin bad++; $display("FAIL rnd_err c=%0d got=%b%b exp=%b%b", c, ovf_err, unf_err, m_ovf, m_unf); end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = 64'd0;
        model_clear();
        test_reset();
        test_first_push();
        test_fill_ovf_drain();
        test_stream();
        test_flush();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/buf_fifo_ctrl.md
Name: buf_fifo_ctrl

Overview:
- Sequencer that turns the team's 8-entry x 64-bit two-port buffer (registered read port, 1-cycle read latency, read data held while read enable is low) into a show-ahead FIFO.
- Valid/ready on both sides.
- Generates the buffer write/read addresses and enables; hides read latency with a prefetch into the buffer's output register.
- Sits between a producer datapath and a consumer; the buffer is instantiated alongside it at the integration level.

Parameters:
- DW, 64, data width; must equal the buffer width.
- AW, 3, buffer address width; DEPTH = 2**AW = 8.
- AFULL_THR, 6, level at or above which afull asserts.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- flush  in  1  synchronous clear of FIFO state
- s_valid  in  1  producer data valid
- s_ready  out  1  controller can accept a push
- s_data  in  DW  producer data
- m_valid  out  1  m_data holds a valid head entry
- m_ready  in  1  consumer accepts head
- m_data  out  DW  head data; wired straight from buf_rd_data
- buf_wr_en  out  1  buffer write enable
- buf_addr_wr  out  AW  buffer write address
- buf_wr_data  out  DW  buffer write data (= s_data)
- buf_rd_en  out  1  buffer read enable
- buf_addr_rd  out  AW  buffer read address
- buf_rd_data  in  DW  buffer registered read data
- level  out  AW+1  total occupancy, 0..DEPTH+1
- afull  out  1  level >= AFULL_THR
- ovf_err  out  1  sticky: s_valid seen while s_ready low and level==DEPTH+1
- unf_err  out  1  sticky: m_ready seen while m_valid low

Behaviour:
- State registers:
  - wptr, rptr: AW+1 bits each; MSB is the wrap bit.
  - mem_cnt: 0..DEPTH, entries in the buffer not yet fetched.
  - m_valid.
- Reset: wptr=rptr=0, mem_cnt=0, m_valid=0, ovf_err=unf_err=0. Outputs are 0 throughout reset, including s_ready, buf_wr_en and buf_rd_en.
- Push:
  - s_ready = (mem_cnt != DEPTH) & !flush.
  - push = s_valid & s_ready.
  - buf_wr_en = push, buf_addr_wr = wptr[AW-1:0].
  - wptr increments modulo 2**(AW+1).
- Fetch:
  - fetch = (mem_cnt != 0) & (!m_valid | m_ready) & !flush.
  - buf_rd_en = fetch, buf_addr_rd = rptr[AW-1:0].
  - rptr increments on fetch.
  - Because mem_cnt is registered, an entry written in cycle N is fetchable no earlier than N+1, so there is never a same-address write/read in one cycle.
- m_valid next state:
  - set on fetch;
  - else cleared when m_ready;
  - flush clears it.
- Pop = m_valid & m_ready. m_data stays stable while m_valid & !m_ready, since the buffer holds read data while read enable is low.
- mem_cnt next = mem_cnt + push - fetch. Simultaneous push and fetch leaves it unchanged.
- level = mem_cnt + m_valid (registered sources, combinational sum); maximum DEPTH+1 = 9.
- Latency:
  - First push into an empty FIFO at edge N: m_valid rises after edge N+2 (fetch issued cycle N+1).
  - Steady state with m_ready held high: one entry per cycle.
- Wrap-around: pointer low bits roll 7->0 and the wrap bit toggles. Full and empty are judged only by mem_cnt.
- Flush:
  - pointers, mem_cnt and m_valid go to 0 next edge;
  - buffer contents are not cleared;
  - no push or fetch is issued in the flush cycle;
  - sticky errors are kept.
- Errors: ovf_err and unf_err clear only on rst.
- Reset mid-operation: immediate return to reset values; an in-flight fetch is discarded.

Decomposition:
- Package buf_fifo_pkg holds DW, AW, DEPTH constants and the level type, logic [AW:0].
- One natural sub-module: buf_fifo_ptr, a wrap pointer with increment enable and synchronous clear, instantiated twice (write and read).

Test Plan:
- Reset, then push 0xA5A5_0000_0000_0001 at cycle 1 with m_ready=0 -> buf_wr_en=1 and buf_addr_wr=0 at cycle 1; buf_rd_en=1 and buf_addr_rd=0 at cycle 2; m_valid=1 and m_data=0xA5A5_0000_0000_0001 from cycle 3; level=1.
- Push 9 words 0..8 with m_ready=0 -> s_ready drops after the 9th push, level=9, afull=1 from level 6. An extra s_valid sets ovf_err=1 with no write.
- With full FIFO, hold m_ready=1 -> words 0..8 pop in order on 9 consecutive cycles after m_valid; level reaches 0; m_valid=0.
- Stream 20 words with s_valid=1 and m_ready=1 continuously -> addresses wrap 7->0 twice, output order equals input order, no stalls after the 2-cycle fill.
- FIFO at level 5, assert flush with s_valid=1 -> no buf_wr_en or buf_rd_en that cycle; next cycle level=0, m_valid=0, s_ready=1; a new push of 0x77 is the next word out.
- Assert rst mid-stream at level 4 with a fetch pending -> all outputs 0 immediately; after release, level=0 and the first push is read from address 0.
